line_read_serializer: RTL and testbench

//   Downstream of the 8-way 256-bit line select mux. Captures the selected

---
 rtl/line_read_serializer.sv | 72 +++++++
 tb/tb_line_read_serializer.sv | 123 ++++++++++++
 2 files changed

// File: rtl/line_read_serializer.sv
// line_read_serializer: captures a cache line and streams it out as wrap-ordered word beats
module line_read_serializer #(
  parameter int LINE_W = 256,
  parameter int WORD_W = 32,
  localparam int N_WORDS = LINE_W / WORD_W,
  localparam int IDX_W = $clog2(N_WORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LINE_W-1:0] line_in,
  input  logic              line_valid,
  output logic              line_ready,
  input  logic [IDX_W-1:0]  start_off,
  input  logic              single,
  input  logic              flush,
  output logic [WORD_W-1:0] word_out,
  output logic [IDX_W-1:0]  word_idx,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              word_last,
  output logic              busy
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state_q, state_d;
  logic [N_WORDS-1:0][WORD_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0] off_q, off_d, cnt_q, cnt_d;
  logic single_q, single_d;
  // state register and captured burst context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      buf_q    <= '0;
      off_q    <= '0;
      cnt_q    <= '0;
      single_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      off_q    <= off_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
    end
  end
  // accept a line in IDLE, walk the beats in SEND; flush ends a burst regardless of handshake
  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    off_d      = off_q;
    cnt_d      = cnt_q;
    single_d   = single_q;
    line_ready = rst_n && state_q == IDLE && !flush;
    word_valid = state_q == SEND;
    busy       = word_valid;
    word_idx   = off_q + cnt_q;
    word_out   = buf_q[word_idx];
    word_last  = word_valid && (single_q || cnt_q == IDX_W'(N_WORDS - 1));
    if (line_valid && line_ready) begin
      buf_d    = line_in;
      off_d    = start_off;
      single_d = single;
      cnt_d    = '0;
      state_d  = SEND;
    end
    if (word_valid) begin
      if (flush) state_d = IDLE;
      else if (word_ready) begin
        cnt_d   = cnt_q + 1'b1;
        state_d = word_last ? IDLE : SEND;
      end
    end
  end
endmodule

// File: tb/tb_line_read_serializer.sv
// tb_line_read_serializer: random and directed bursts checked against a word-array reference model
module tb_line_read_serializer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [255:0] line_in = '0;
  logic line_valid = 1'b0, line_ready, single = 1'b0, flush = 1'b0, word_ready = 1'b0;
  logic [2:0] start_off = '0, word_idx;
  logic [31:0] word_out;
  logic word_valid, word_last, busy;
  int checks = 0, errors = 0;
  logic [31:0] m_line [8];
  int m_off = 0, m_n = 0, dut_n = 0;
  bit m_single = 0, m_active = 0;

  line_read_serializer dut (
    .clk(clk), .rst_n(rst_n), .line_in(line_in), .line_valid(line_valid),
    .line_ready(line_ready), .start_off(start_off), .single(single), .flush(flush),
    .word_out(word_out), .word_idx(word_idx), .word_valid(word_valid),
    .word_ready(word_ready), .word_last(word_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // one clock: drive inputs after the falling edge, compare, then advance the model
  task automatic cyc(input bit lv, input int off, input bit sg, input bit fl, input bit wr, input bit rnd);
    int idx;
    @(negedge clk);
    line_valid = lv; start_off = 3'(off); single = sg; flush = fl; word_ready = wr;
    for (int k = 0; k < 8; k++) line_in[k*32 +: 32] = rnd ? $urandom : 32'hA000_0000 + k;
    #1;
    if (m_active) begin
      idx = (m_off + m_n) % 8;
      check("valid", word_valid, 1);
      check("busy", busy, 1);
      check("ready_send", line_ready, 0);
      check("idx", word_idx, idx);
      check("data", word_out, m_line[idx]);
      check("last", word_last, m_single || m_n == 7);
      if (word_valid && word_ready) dut_n++;
      if (fl) m_active = 0;
      else if (wr) begin
        m_n++;
        if (m_single || m_n == 8) begin
          check("beats", dut_n, m_single ? 1 : 8);
          m_active = 0;
        end
      end
    end else begin
      check("valid_idle", word_valid, 0);
      check("busy_idle", busy, 0);
      check("ready_idle", line_ready, !fl);
      if (lv && !fl) begin
        for (int k = 0; k < 8; k++) m_line[k] = line_in[k*32 +: 32];
        m_off = off; m_single = sg; m_n = 0; dut_n = 0; m_active = 1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; flush = 1'b0; line_valid = 1'b0;
    #1;
    check("rst_valid", word_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", line_ready, 0);
    check("rst_last", word_last, 0);
    check("rst_data", word_out, 0);
    check("rst_idx", word_idx, 0);
    m_active = 0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_ready", line_ready, 1);
  endtask

  initial begin
    do_reset();
    // full burst from word 0, consumer always ready
    cyc(1, 0, 0, 0, 1, 0);
    repeat (9) cyc(0, 0, 0, 0, 1, 1);
    // wrap from word 5
    cyc(1, 5, 0, 0, 1, 0);
    repeat (9) cyc(0, 0, 0, 0, 1, 1);
    // single word read
    cyc(1, 3, 1, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 1);
    // random backpressure
    cyc(1, 0, 0, 0, 0, 0);
    repeat (30) cyc(0, 0, 0, 0, 1'($urandom), 1);
    repeat (2) cyc(0, 0, 0, 0, 1, 1);
    // flush after three beats, then a flush coincident with a handshake
    cyc(1, 2, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 0, 1);
    cyc(1, 6, 0, 0, 1, 0);
    repeat (2) cyc(0, 0, 0, 0, 1, 1);
    cyc(0, 0, 0, 1, 1, 1);
    cyc(1, 1, 0, 0, 1, 0);
    repeat (9) cyc(0, 0, 0, 0, 1, 1);
    // flush in IDLE blocks accept
    cyc(1, 4, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 1);
    // reset mid-burst
    cyc(1, 7, 0, 0, 1, 0);
    repeat (3) cyc(0, 0, 0, 0, 1, 1);
    do_reset();
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else cyc(1'($urandom), $urandom_range(0, 7), $urandom_range(0, 3) == 0,
               $urandom_range(0, 15) == 0, 1'($urandom), 1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
